// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between instruction fetch and data access.
// Round-robin grant, MREQ/ACK handshake with bounded wait, one-cycle completion pulse.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_oe,
    input  logic [31:0] bus_rdata,
    output logic        bus_mreq,
    output logic        bus_write,
    output logic [1:0]  bus_size,
    input  logic        bus_ack_n,
    output logic        bus_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             last_mem, last_mem_nx;
    logic             owner_mem, owner_mem_nx;
    logic             pick_mem;
    logic             finish;
    logic [DW-1:0]    cap_data;

    logic [AW-1:0]    bus_addr_nx;
    logic [DW-1:0]    bus_wdata_nx;
    logic             bus_oe_nx, bus_mreq_nx, bus_write_nx, bus_err_nx;
    logic [1:0]       bus_size_nx;
    logic [DW-1:0]    if_rdata_nx, mem_rdata_nx;
    logic             if_ready_nx, mem_ready_nx;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;
    assign cnt_inc   = cnt + CNT_W'(1);

    // Lone requester wins outright; on contention the side that did not win last time wins.
    assign pick_mem = mem_req & (~if_req | ~last_mem);

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        last_mem_nx  = last_mem;
        owner_mem_nx = owner_mem;
        bus_addr_nx  = bus_addr;
        bus_wdata_nx = bus_wdata;
        bus_oe_nx    = bus_oe;
        bus_mreq_nx  = bus_mreq;
        bus_write_nx = bus_write;
        bus_size_nx  = bus_size;
        bus_err_nx   = 1'b0;
        if_ready_nx  = 1'b0;
        mem_ready_nx = 1'b0;
        if_rdata_nx  = if_rdata;
        mem_rdata_nx = mem_rdata;
        finish       = 1'b0;
        cap_data     = '0;

        case (state)
            S_IDLE: begin
                if (if_req | mem_req) begin
                    owner_mem_nx = pick_mem;
                    last_mem_nx  = pick_mem;
                    bus_addr_nx  = pick_mem ? mem_addr : if_addr;
                    bus_size_nx  = pick_mem ? mem_size : 2'b11;
                    bus_write_nx = pick_mem & mem_we;
                    bus_oe_nx    = pick_mem & mem_we;
                    bus_wdata_nx = pick_mem ? mem_wdata : '0;
                    bus_mreq_nx  = 1'b1;
                    cnt_nx       = '0;
                    state_nx     = S_WAIT;
                end
            end
            S_WAIT: begin
                // Acknowledge takes priority over a timeout landing on the same edge.
                if (!bus_ack_n) begin
                    finish   = 1'b1;
                    cap_data = bus_write ? '0 : bus_rdata;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    finish     = 1'b1;
                    bus_err_nx = 1'b1;
                    cnt_nx     = cnt_inc;
                end else begin
                    cnt_nx = cnt_inc;
                end
                if (finish) begin
                    bus_mreq_nx = 1'b0;
                    bus_oe_nx   = 1'b0;
                    state_nx    = S_DONE;
                    if (owner_mem) begin
                        mem_ready_nx = 1'b1;
                        mem_rdata_nx = cap_data;
                    end else begin
                        if_ready_nx = 1'b1;
                        if_rdata_nx = cap_data;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_mem  <= 1'b0;
            owner_mem <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_oe    <= 1'b0;
            bus_mreq  <= 1'b0;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_err   <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last_mem  <= last_mem_nx;
            owner_mem <= owner_mem_nx;
            bus_addr  <= bus_addr_nx;
            bus_wdata <= bus_wdata_nx;
            bus_oe    <= bus_oe_nx;
            bus_mreq  <= bus_mreq_nx;
            bus_write <= bus_write_nx;
            bus_size  <= bus_size_nx;
            bus_err   <= bus_err_nx;
            if_ready  <= if_ready_nx;
            mem_ready <= mem_ready_nx;
            if_rdata  <= if_rdata_nx;
            mem_rdata <= mem_rdata_nx;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus (address, data, MREQ, WRITE, SIZE, active-low ACK) between instruction fetch (IF) and data access (MEM).
- Sequences each bus transaction through a request/acknowledge handshake and returns the read data to the winning requester.
- Drives per-requester stall signals so the pipeline holds until its access completes.
- Sits between the IF and MEM stages and the top-level bus pins.

Parameters:
TIMEOUT, 15, maximum number of WAIT cycles without acknowledge before the transaction is aborted (1..255)
CNT_W, 8, width of the wait counter; must satisfy TIMEOUT < 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request; held high with if_addr stable until if_ready
if_addr  input  32  fetch address
if_rdata  output  32  fetched instruction; valid while if_ready
if_ready  output  1  one-cycle pulse: fetch complete
mem_req  input  1  data request; held with payload stable until mem_ready
mem_we  input  1  1 = store, 0 = load
mem_size  input  2  access size, passed unchanged to bus_size
mem_addr  input  32  data address
mem_wdata  input  32  store data
mem_rdata  output  32  load data; valid while mem_ready
mem_ready  output  1  one-cycle pulse: data access complete
stall_if  output  1  high while if_req is pending and not yet completed
stall_mem  output  1  high while mem_req is pending and not yet completed
bus_addr  output  32  bus address
bus_wdata  output  32  bus write data
bus_oe  output  1  drive enable for the bidirectional data bus
bus_rdata  input  32  bus read data
bus_mreq  output  1  memory request, active-high
bus_write  output  1  write strobe, active-high
bus_size  output  2  access size
bus_ack_n  input  1  acknowledge, active-low
bus_err  output  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset (rst=0, asynchronous) forces the following, immediately and regardless of clk:
  - State IDLE; wait counter 0; last_grant = IF.
  - All outputs 0, including bus_mreq, bus_oe, both ready pulses, bus_err, both rdata outputs and all bus_* outputs.
- Stalls are combinational: stall_x = x_req & ~x_ready.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Only IF requests: grant IF.
  - Only MEM requests: grant MEM.
  - Both request: grant the requester opposite to last_grant (round-robin). Tie-break after reset favours MEM.
  - On grant, register at the clock edge: address, size (11 for IF), write (mem_we for MEM, 0 for IF), wdata, and bus_oe = write. Also set bus_mreq = 1, counter = 0, last_grant = winner, and go to WAIT.
  - No request: stay in IDLE with bus_mreq = 0.
- WAIT:
  - bus_* outputs stay constant.
  - bus_ack_n sampled 0 at a clock edge: capture bus_rdata (loads and fetches only), drop bus_mreq and bus_oe, and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: drop bus_mreq and bus_oe, set the captured data to 0, set bus_err for the DONE cycle, and go to DONE.
- DONE (exactly one cycle):
  - Pulse the winner's x_ready with the captured data on x_rdata. Store completion also pulses ready; mem_rdata = 0.
  - Return to IDLE. A new grant is possible on the next edge, so bus_mreq is low for at least one cycle between transactions.
- Latency from request (seen in IDLE) to ready:
  - Ack on the first WAIT cycle: grant edge, ack edge, ready in the following cycle (3 cycles).
  - Each extra WAIT cycle adds 1.
- Rdata outputs hold their last value outside the ready pulse.
- A request deasserted before its ready pulse is a protocol violation. The transaction still completes and the ready pulse is still issued.
- A requester may re-assert in the cycle after its ready pulse. It re-arbitrates in IDLE against the other requester using round-robin.
- bus_ack_n = 0 seen in IDLE or DONE is ignored.
- Late acknowledge after a timeout is ignored (the arbiter is in IDLE or has already started a new transaction).

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; bus_ack_n low on the 1st WAIT cycle with bus_rdata=0x00000013 -> bus_addr=0x100, bus_size=11, bus_write=0; if_ready pulses 3 cycles after the request with if_rdata=0x13; stall_if high until then.
- Store then fetch contention: mem_req (we=1, addr=0x2000, wdata=0xDEADBEEF, size=10) and if_req asserted together after reset -> MEM granted first with bus_oe=1, bus_wdata=0xDEADBEEF; after mem_ready, IF is granted; stall_if stays high throughout.
- Round-robin: both requesters asserted continuously, acknowledge every first WAIT cycle -> grants alternate MEM, IF, MEM, IF; neither waits more than one foreign transaction.
- Wait states: load at 0x3004 with ack delayed 4 cycles -> bus_mreq high for 5 cycles; mem_ready 7 cycles after request with mem_rdata equal to the bus_rdata sampled at ack.
- Timeout: TIMEOUT=15, bus_ack_n held 1 -> bus_mreq drops after 15 WAIT cycles; bus_err and mem_ready pulse together with mem_rdata=0; a next request is granted normally.
- Reset mid-transaction: rst low during WAIT -> bus_mreq and bus_oe go to 0 without a clock edge; after release, state is IDLE, no ready pulse occurs, and the next simultaneous request goes to MEM.
